// File: rtl/uart_tx_core.sv
// uart_tx_core: UART serial transmit engine.
//   Sends one frame per accepted rising edge of i_start_tx: start bit,
//   5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Ports:
//   clk, reset_n        clock (rising edge), async active-low reset
//   i_tx_data[7:0]      payload, only the low n bits are sent
//   i_data_bit_num[1:0] data bit count, n = 5 + value
//   i_stop_bit_num      0 = one stop bit, 1 = two
//   i_parity_en         1 = append parity bit
//   i_parity_type       0 = even, 1 = odd
//   i_start_tx          level; a rising edge requests a frame
//   o_tx                registered serial line, idle high
//   o_tx_busy           high while a frame is in progress
//   o_tx_done           sticky completion flag, cleared by the next frame
module uart_tx_core #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] i_tx_data,
    input  logic [1:0] i_data_bit_num,
    input  logic       i_stop_bit_num,
    input  logic       i_parity_en,
    input  logic       i_parity_type,
    input  logic       i_start_tx,
    output logic       o_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic             r_stop_idx;
    logic             r_start_prev;

    // Frame configuration captured when a frame is accepted
    logic [7:0]       r_sh_data;
    logic [1:0]       r_sh_bits;
    logic             r_sh_stop;
    logic             r_sh_par_en;
    logic             r_sh_par_type;

    logic             w_start_edge;
    logic             w_baud_wrap;
    logic [2:0]       w_last_bit;
    logic [2:0]       w_next_idx;
    logic [7:0]       w_data_mask;
    logic             w_parity;

    assign w_start_edge = i_start_tx & ~r_start_prev;
    assign w_baud_wrap  = (r_baud_cnt == BAUD_LAST);
    assign w_last_bit   = 3'd4 + {1'b0, r_sh_bits};
    assign w_next_idx   = r_bit_idx + 3'd1;
    // Mask keeps only the bits actually sent so unsent upper bits never affect parity
    assign w_data_mask  = 8'(8'hFF >> (2'd3 - r_sh_bits));
    assign w_parity     = (^(r_sh_data & w_data_mask)) ^ r_sh_par_type;

    // Frame sequencer with registered line and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_baud_cnt    <= '0;
            r_bit_idx     <= '0;
            r_stop_idx    <= 1'b0;
            r_start_prev  <= 1'b0;
            r_sh_data     <= '0;
            r_sh_bits     <= '0;
            r_sh_stop     <= 1'b0;
            r_sh_par_en   <= 1'b0;
            r_sh_par_type <= 1'b0;
            o_tx          <= 1'b1;
            o_tx_busy     <= 1'b0;
            o_tx_done     <= 1'b0;
        end else begin
            r_start_prev <= i_start_tx;

            // Bit timer runs only while a frame is on the line
            if (r_state == S_IDLE || w_baud_wrap) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + CNT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_sh_data     <= i_tx_data;
                        r_sh_bits     <= i_data_bit_num;
                        r_sh_stop     <= i_stop_bit_num;
                        r_sh_par_en   <= i_parity_en;
                        r_sh_par_type <= i_parity_type;
                        r_bit_idx     <= '0;
                        r_stop_idx    <= 1'b0;
                        r_state       <= S_START;
                        o_tx          <= 1'b0;
                        o_tx_busy     <= 1'b1;
                        o_tx_done     <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_baud_wrap) begin
                        r_state <= S_DATA;
                        o_tx    <= r_sh_data[0];
                    end
                end
                S_DATA: begin
                    if (w_baud_wrap) begin
                        if (r_bit_idx == w_last_bit) begin
                            if (r_sh_par_en) begin
                                r_state <= S_PARITY;
                                o_tx    <= w_parity;
                            end else begin
                                r_state <= S_STOP;
                                o_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= w_next_idx;
                            o_tx      <= r_sh_data[w_next_idx];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_baud_wrap) begin
                        r_state <= S_STOP;
                        o_tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_wrap) begin
                        if (r_stop_idx == r_sh_stop) begin
                            r_state   <= S_IDLE;
                            o_tx_busy <= 1'b0;
                            o_tx_done <= 1'b1;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    o_tx      <= 1'b1;
                    o_tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
